// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: N-requester arbiter for a single shared resource.
//
// - Round-robin selection: the search starts at ptr and wraps N-1 -> 0.
// - Every grant passes through one IDLE cycle, so there are no back-to-back
//   grants.
// - When MAX_HOLD > 0, a holder is preempted after MAX_HOLD consecutive
//   cycles if another requester is waiting. timeout_pulse marks the IDLE
//   cycle that follows such a forced release.
// - All outputs are registered.
//
// Optional build macro ARB_FIXED_PRIO_EN: ptr stays at 0, so the lowest set
// request index always wins (legacy fixed-priority behaviour). The timeout
// still applies in that mode.
module rr_arbiter_fsm #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout_pulse
);

    // hold_cnt needs to reach MAX_HOLD; keep at least one bit when disabled.
    localparam int  HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit  TO_EN    = (MAX_HOLD > 0);
    localparam int  HOLD_LIM = TO_EN ? (MAX_HOLD - 1) : 0;
    localparam int  HOLD_SAT = TO_EN ? MAX_HOLD : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [N-1:0]     gnt_q;
    logic [IDW-1:0]   gnt_id_q;
    logic             gnt_valid_q;
    logic             timeout_pulse_q;
    logic [IDW-1:0]   ptr_q;
    logic [HCW-1:0]   hold_cnt_q;

    logic [N-1:0]     upper_req;
    logic [IDW-1:0]   win_id_d;
    logic [N-1:0]     win_onehot_d;
    logic [IDW-1:0]   ptr_d;
    logic             holder_req;
    logic             others_req;
    logic             timeout_hit;

    // Winner search: the lowest set bit at or above ptr, otherwise the lowest
    // set bit overall (the wrap-around case).
    always_comb begin
        upper_req = '0;
        win_id_d  = '0;
        for (int i = 0; i < N; i++) begin
            upper_req[i] = req[i] && (i >= int'(ptr_q));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id_d = IDW'(i);
            end
        end
        if (|upper_req) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper_req[i]) begin
                    win_id_d = IDW'(i);
                end
            end
        end
    end

    // One-hot form of the winner, built from the same index so gnt and
    // gnt_id cannot disagree.
    always_comb begin
        win_onehot_d = '0;
        for (int i = 0; i < N; i++) begin
            win_onehot_d[i] = (win_id_d == IDW'(i));
        end
    end

    // Next pointer: one past the winner in round-robin mode, pinned at 0 in
    // fixed-priority mode.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (win_id_d == IDW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_id_d + IDW'(1);
        end
`endif
    end

    // Holder status and the preemption condition evaluated during GRANT.
    always_comb begin
        holder_req  = |(req & gnt_q);
        others_req  = |(req & ~gnt_q);
        timeout_hit = TO_EN && (hold_cnt_q == HCW'(HOLD_LIM)) && others_req;
    end

    // Arbiter FSM with registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            gnt_q           <= '0;
            gnt_id_q        <= '0;
            gnt_valid_q     <= 1'b0;
            timeout_pulse_q <= 1'b0;
            ptr_q           <= '0;
            hold_cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_pulse_q <= 1'b0;
                    if (|req) begin
                        state_q     <= GRANT;
                        gnt_q       <= win_onehot_d;
                        gnt_id_q    <= win_id_d;
                        gnt_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        hold_cnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!holder_req) begin
                        // A plain release takes priority over a coincident timeout.
                        state_q         <= IDLE;
                        gnt_q           <= '0;
                        gnt_id_q        <= '0;
                        gnt_valid_q     <= 1'b0;
                        timeout_pulse_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q         <= IDLE;
                        gnt_q           <= '0;
                        gnt_id_q        <= '0;
                        gnt_valid_q     <= 1'b0;
                        timeout_pulse_q <= 1'b1;
                    end else if (hold_cnt_q != HCW'(HOLD_SAT)) begin
                        hold_cnt_q <= hold_cnt_q + HCW'(1);
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    gnt_q           <= '0;
                    gnt_id_q        <= '0;
                    gnt_valid_q     <= 1'b0;
                    timeout_pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign gnt_id        = gnt_id_q;
    assign gnt_valid     = gnt_valid_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule
